// File: rtl/otter_fetch.sv
// Instruction fetch stage: single-outstanding imem reads, registered output with a 1-entry skid buffer.
// Optional FETCH_MISALIGN_CHK_EN: misaligned PCs fault locally instead of issuing a read.
module otter_fetch #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  output logic        pc_w_en,
  input  logic        redirect,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  output logic [2:0]  fsm_state
);

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_FAULT} state_t;
`else
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;
`endif

  state_t      state, state_n;
  logic [31:0] req_pc;
  logic        skid_full;
  logic [31:0] skid_instr, skid_pc;
  logic        skid_fault;

  logic        req_valid, req_fire, slot_free;
  logic        load_out, load_skid, pop_skid;
  logic [31:0] ld_instr, ld_pc;
  logic        ld_fault;

  // Handshake rule: a channel transfers on a cycle where valid & ready are both high at the
  // clock edge; a raised request valid holds with a stable address until it transfers, except
  // that redirect withdraws it. The response channel has no ready and always transfers.
  assign slot_free     = ~instr_valid | instr_ready;
  assign req_fire      = req_valid & imem_req_ready;
  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_addr;
  assign pc_w_en        = ~rst & (redirect | req_fire);
  assign fsm_state      = state;

  always_comb begin
    state_n   = state;
    req_valid = 1'b0;
    load_out  = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    ld_instr  = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
    ld_pc     = req_pc;
    ld_fault  = imem_rsp_err;
    case (state)
      S_REQ: begin
`ifdef FETCH_MISALIGN_CHK_EN
        if (pc_addr[1:0] != 2'b00) begin
          if (slot_free) begin
            load_out = 1'b1;
            ld_instr = NOP_INSTR;
            ld_pc    = pc_addr;
            ld_fault = 1'b1;
            state_n  = S_FAULT;
          end
        end else
`endif
        begin
          req_valid = ~rst & ~redirect & ~skid_full;
          if (req_valid & imem_req_ready) state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (slot_free) begin
            load_out = 1'b1;
            state_n  = S_REQ;
          end else begin
            load_skid = 1'b1;
            state_n   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pop_skid = 1'b1;
          state_n  = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) state_n = S_REQ;
      end
      default: state_n = state;
    endcase
    // A response arriving with the redirect retires the outstanding read, so no drain is needed.
    if (redirect) begin
      if ((state == S_WAIT || state == S_DRAIN) && !imem_rsp_valid) state_n = S_DRAIN;
      else state_n = S_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      req_pc      <= 32'h0;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'h0;
      instr_fault <= 1'b0;
      skid_full   <= 1'b0;
      skid_instr  <= NOP_INSTR;
      skid_pc     <= 32'h0;
      skid_fault  <= 1'b0;
    end else begin
      state <= state_n;
      if (req_fire) req_pc <= pc_addr;
      if (redirect) begin
        instr_valid <= 1'b0;
        instr       <= NOP_INSTR;
        instr_fault <= 1'b0;
        skid_full   <= 1'b0;
      end else if (load_out) begin
        instr_valid <= 1'b1;
        instr       <= ld_instr;
        instr_pc    <= ld_pc;
        instr_fault <= ld_fault;
      end else if (pop_skid) begin
        instr_valid <= 1'b1;
        instr       <= skid_instr;
        instr_pc    <= skid_pc;
        instr_fault <= skid_fault;
        skid_full   <= 1'b0;
      end else if (instr_valid & instr_ready) begin
        instr_valid <= 1'b0;
        instr       <= NOP_INSTR;
        instr_fault <= 1'b0;
      end
      if (!redirect && load_skid) begin
        skid_full  <= 1'b1;
        skid_instr <= ld_instr;
        skid_pc    <= ld_pc;
        skid_fault <= ld_fault;
      end
    end
  end

endmodule
